// File: rtl/nlynx_snapshot_streamer.sv
// Captures one snapshot of the NLYNX counters per end-of-program edge into a
// small circular buffer and streams each snapshot out as a framed word packet.
//
// state | meaning
// IDLE  | nothing presented, waiting for a buffered snapshot
// HDR   | header word of the slot at rd_ptr presented
// PAY   | counter word idx of the slot at rd_ptr presented
module nlynx_snapshot_streamer #(
  parameter int NLYNX_METRICS       = 13,
  parameter int NLYNX_COUNTER_WIDTH = 32,
  parameter int DEPTH               = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          eop_i,
  input  logic [NLYNX_METRICS-1:0]      overflow_i,
  input  logic [NLYNX_METRICS*32-1:0]   cnt_i,
  output logic [31:0]                   m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic                          m_last_o,
  output logic [15:0]                   drop_cnt_o,
  output logic                          busy_o
);

  if (NLYNX_COUNTER_WIDTH != 32) begin : g_width_chk
    $error("nlynx_snapshot_streamer: NLYNX_COUNTER_WIDTH must be 32");
  end
  if (NLYNX_METRICS < 1 || NLYNX_METRICS > 16) begin : g_metrics_chk
    $error("nlynx_snapshot_streamer: NLYNX_METRICS must be 1..16");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("nlynx_snapshot_streamer: DEPTH must be a power of two");
  end

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NLYNX_METRICS > 1) ? $clog2(NLYNX_METRICS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  logic                        eop_q;
  logic [7:0]                  seq;
  logic [CW-1:0]               count;
  logic [CW-1:0]               count_nxt;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  logic [IW-1:0]               idx;
  logic                        cap_event;
  logic                        full;
  logic                        push;
  logic                        drop;
  logic                        hs;
  logic                        pop;
  logic [31:0]                 hdr_word;
  logic [31:0]                 pay_word;

  logic [NLYNX_METRICS*32-1:0] cnt_mem [DEPTH];
  logic [NLYNX_METRICS-1:0]    ovf_mem [DEPTH];
  logic [7:0]                  seq_mem [DEPTH];

  assign cap_event = eop_i & ~eop_q;
  assign full      = (count == CW'(DEPTH));
  // A pop in the same cycle never frees room for a push: fullness is judged
  // on the count at the start of the cycle.
  assign push      = cap_event & ~full;
  assign drop      = cap_event & full;
  assign hs        = m_valid_o & m_ready_i;
  assign pop       = hs & (state == ST_PAY) & (idx == IW'(NLYNX_METRICS - 1));
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (count != '0 || push) state_nxt = ST_HDR;
      ST_HDR:  if (hs) state_nxt = ST_PAY;
      ST_PAY:  if (pop) state_nxt = (count_nxt != '0) ? ST_HDR : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eop_q      <= 1'b0;
      seq        <= '0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= ST_IDLE;
      idx        <= '0;
      drop_cnt_o <= '0;
    end else begin
      eop_q <= eop_i;
      state <= state_nxt;
      count <= count_nxt;
      if (cap_event) seq <= seq + 8'd1;
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      if (hs) idx <= (state == ST_HDR) ? '0 : idx + 1'b1;
    end
  end

  // Slot storage carries no reset: a slot is only read while it is occupied.
  always_ff @(posedge clk_i) begin
    if (push) begin
      cnt_mem[wr_ptr] <= cnt_i;
      ovf_mem[wr_ptr] <= overflow_i;
      seq_mem[wr_ptr] <= seq;
    end
  end

  always_comb begin
    hdr_word                      = '0;
    hdr_word[31:24]               = 8'hD1;
    hdr_word[23:16]               = seq_mem[rd_ptr];
    hdr_word[NLYNX_METRICS-1:0]   = ovf_mem[rd_ptr];
  end

  assign pay_word  = cnt_mem[rd_ptr][32*int'(idx) +: 32];
  assign m_valid_o = (state == ST_HDR) || (state == ST_PAY);
  assign m_last_o  = (state == ST_PAY) && (idx == IW'(NLYNX_METRICS - 1));
  assign m_data_o  = (state == ST_HDR) ? hdr_word :
                     (state == ST_PAY) ? pay_word : 32'd0;
  assign busy_o    = (count != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_nlynx_snapshot_streamer.sv
// Bench for nlynx_snapshot_streamer: reference model queues the expected packet
// words per accepted snapshot; an independent monitor pops them on handshakes.
module tb_nlynx_snapshot_streamer;
  localparam int M     = 13;
  localparam int DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            eop_i = 1'b0;
  logic            m_ready_i = 1'b0;
  logic [M-1:0]    overflow_i = '0;
  logic [M*32-1:0] cnt_i = '0;
  logic [31:0]     m_data_o;
  logic            m_valid_o;
  logic            m_last_o;
  logic [15:0]     drop_cnt_o;
  logic            busy_o;

  nlynx_snapshot_streamer #(.NLYNX_METRICS(M), .NLYNX_COUNTER_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .eop_i(eop_i), .overflow_i(overflow_i), .cnt_i(cnt_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pushed = 0;
  int         pops = 0;
  int         hs_cnt = 0;
  int         model_drops = 0;
  logic [7:0] model_seq = '0;
  logic       eop_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [M*32-1:0] rand_cnt();
    logic [M*32-1:0] r;
    for (int k = 0; k < M; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Apply inputs at a falling edge, update the model for the coming rising
  // edge, then advance to the next falling edge.
  task automatic drive(input logic eop, input logic rdy, input logic [M*32-1:0] cnt,
                       input logic [M-1:0] ovf);
    eop_i = eop;
    m_ready_i = rdy;
    cnt_i = cnt;
    overflow_i = ovf;
    if (eop && !eop_prev) begin
      if (pushed - pops < DEPTH) begin
        exp_q.push_back('{data: 32'hD100_0000 | (32'(model_seq) << 16) | 32'(ovf), last: 1'b0});
        for (int k = 0; k < M; k++) exp_q.push_back('{data: cnt[k*32 +: 32], last: (k == M - 1)});
        pushed++;
      end else if (model_drops < 65535) begin
        model_drops++;
      end
      model_seq = model_seq + 8'd1;
    end
    eop_prev = eop;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    eop_i = 1'b0;
    m_ready_i = 1'b0;
    exp_q.delete();
    pushed = 0;
    pops = 0;
    model_drops = 0;
    model_seq = '0;
    eop_prev = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < budget) begin
      drive(1'b0, 1'b1, cnt_i, overflow_i);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
    chk("drain_busy", 32'(busy_o), 32'd0);
    chk("drop_cnt", 32'(drop_cnt_o), 32'(model_drops));
  endtask

  initial begin : monitor
    logic        pv;
    logic        pr;
    logic        pl;
    logic [31:0] pd;
    word_t       w;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_ni) begin
        chk("rst_valid", 32'(m_valid_o), 32'd0);
        chk("rst_last", 32'(m_last_o), 32'd0);
        chk("rst_data", m_data_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", 32'(m_valid_o), 32'd1);
          chk("hold_data", m_data_o, pd);
          chk("hold_last", 32'(m_last_o), 32'(pl));
        end
        if (!m_valid_o) begin
          chk("idle_data", m_data_o, 32'd0);
          chk("idle_last", 32'(m_last_o), 32'd0);
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h, expected no word", m_data_o);
          end else begin
            w = exp_q.pop_front();
            chk("word_data", m_data_o, w.data);
            chk("word_last", 32'(m_last_o), 32'(w.last));
            hs_cnt++;
            if (w.last) pops++;
          end
        end
        pv = m_valid_o; pr = m_ready_i; pd = m_data_o; pl = m_last_o;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timed out");
  end

  initial begin : stimulus
    logic [M*32-1:0] c;
    int              h0;
    int              p0;
    int              d0;
    logic            found;
    @(negedge clk_i);
    do_reset();
    chk("post_rst_valid", 32'(m_valid_o), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    // single snapshot with a known pattern
    for (int k = 0; k < M; k++) c[k*32 +: 32] = 32'h1000 + k;
    drive(1'b0, 1'b1, c, 13'h0005);
    drive(1'b1, 1'b1, c, 13'h0005);
    chk("lat_valid", 32'(m_valid_o), 32'd1);
    chk("lat_busy", 32'(busy_o), 32'd1);
    chk("lat_header", m_data_o, 32'hD100_0005);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, c, 13'h0005);
      if (pops == 1) break;
    end
    chk("single_busy_after", 32'(busy_o), 32'd0);
    chk("single_words", 32'(hs_cnt), 32'd14);

    // backpressure 1,0,0,1 with inputs changing after capture
    drive(1'b0, 1'b1, c, 13'h0005);
    p0 = pops;
    drive(1'b1, 1'b1, rand_cnt(), 13'( $urandom));
    for (int i = 0; i < 120; i++) begin
      drive(1'b0, (i % 4 == 0) || (i % 4 == 3), rand_cnt(), 13'($urandom));
      if (pops == p0 + 1) break;
    end
    drain(100);

    // overflow into drop
    do_reset();
    for (int e = 0; e < 4; e++) begin
      drive(1'b1, 1'b0, rand_cnt(), 13'($urandom));
      drive(1'b0, 1'b0, cnt_i, overflow_i);
    end
    chk("ovf_drop_cnt", 32'(drop_cnt_o), 32'd2);
    chk("ovf_busy", 32'(busy_o), 32'd1);
    chk("ovf_first_seq", 32'(m_data_o[23:16]), 32'd0);
    h0 = hs_cnt;
    drain(100);
    chk("ovf_words", 32'(hs_cnt - h0), 32'd28);
    drive(1'b1, 1'b1, rand_cnt(), 13'($urandom));
    chk("ovf_next_seq", 32'(m_data_o[31:16]), 32'h0000_D104);
    drain(100);

    // same-cycle drop: edge coincides with last-beat handshake on a full buffer
    drive(1'b1, 1'b0, rand_cnt(), 13'($urandom));
    drive(1'b0, 1'b0, cnt_i, overflow_i);
    drive(1'b1, 1'b0, rand_cnt(), 13'($urandom));
    drive(1'b0, 1'b0, cnt_i, overflow_i);
    d0 = model_drops;
    h0 = hs_cnt;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_valid_o && m_last_o) begin
        drive(1'b1, 1'b1, rand_cnt(), 13'($urandom));
        found = 1'b1;
      end else begin
        drive(1'b0, 1'b1, cnt_i, overflow_i);
      end
    end
    chk("same_cycle_found", 32'(found), 32'd1);
    chk("same_cycle_drop", 32'(drop_cnt_o), 32'(d0 + 1));
    drain(100);
    chk("same_cycle_words", 32'(hs_cnt - h0), 32'd28);

    // held level gives one packet
    h0 = hs_cnt;
    repeat (10) drive(1'b1, 1'b1, rand_cnt(), 13'($urandom));
    drive(1'b0, 1'b1, cnt_i, overflow_i);
    drain(100);
    chk("level_words", 32'(hs_cnt - h0), 32'd14);

    // 513 randomized events walk the sequence field through its wrap
    for (int e = 0; e < 513; e++) begin
      c = rand_cnt();
      repeat ($urandom_range(1, 3)) drive(1'b1, $urandom_range(0, 3) != 0, c, 13'($urandom));
      repeat ($urandom_range(1, 6)) drive(1'b0, $urandom_range(0, 3) != 0, c, overflow_i);
    end
    drain(400);

    // reset after word 5 of a packet
    drive(1'b1, 1'b1, rand_cnt(), 13'($urandom));
    h0 = hs_cnt - 0;
    for (int i = 0; i < 30; i++) begin
      if (hs_cnt - h0 >= 5) break;
      drive(1'b0, 1'b1, cnt_i, overflow_i);
    end
    chk("mid_words_seen", 32'(hs_cnt - h0 >= 5), 32'd1);
    do_reset();
    drive(1'b1, 1'b1, rand_cnt(), 13'($urandom));
    chk("post_reset_valid", 32'(m_valid_o), 32'd1);
    chk("post_reset_seq", 32'(m_data_o[31:16]), 32'h0000_D100);
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
